// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit.
// Holds jump-kind encodings, branch condition codes, counter states and the BTB entry type.
package bpu_pkg;

    // Storage width for BTB tag/target fields; XLEN must not exceed this.
    localparam int BPU_W = 32;

    typedef enum logic [1:0] {
        JMP_NONE   = 2'b00,
        JMP_BRANCH = 2'b01,
        JMP_JAL    = 2'b10,
        JMP_JALR   = 2'b11
    } jmp_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        KIND_BRANCH = 1'b0,
        KIND_JUMP   = 1'b1
    } btb_kind_e;

    typedef struct packed {
        logic             valid;
        logic [BPU_W-1:0] tag;
        logic [BPU_W-1:0] target;
        btb_kind_e        kind;
    } btb_entry_t;

    // Two-bit saturating counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == ST) ? ST : c + 2'd1;
        end
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps funct3 and compare flags to a taken bit.
// Ports: fun3, n, z, c (no-borrow), v in; cond out. Undefined codes give 0.
module br_cond_eval
    import bpu_pkg::*;
(
    input  logic [2:0] fun3,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (fun3)
            F3_BEQ:  cond = z;
            F3_BNE:  cond = ~z;
            F3_BLT:  cond = n ^ v;
            F3_BGE:  cond = ~(n ^ v);
            F3_BLTU: cond = ~c;
            F3_BGEU: cond = c;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: direct-mapped BHT + tagged BTB looked up in Fetch,
// trained and resolved in Execute, with redirect PC and saturating statistics.
// Ports: clk, reset (sync, active-high); PCF -> PredTakenF/PredTargetF;
// Execute inputs ValidE, JmpE, Fun3E, N/Z/C/V, PCE, TargetE, PredTakenE, PredTargetE;
// outputs PCJmpE, MispredictE, RedirectPCE, BrCount, MissCount.
module branch_pred_unit
    import bpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16,
    parameter bit PRED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             ValidE,
    input  logic [1:0]       JmpE,
    input  logic [2:0]       Fun3E,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  TargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             PCJmpE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t btb [DEPTH];
    logic [1:0] ctr [DEPTH];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic [BPU_W-1:0] tag_f;
    logic [BPU_W-1:0] tag_e;
    logic             hit_f;
    logic             hit_e;
    logic             cond_e;
    btb_entry_t       wr_entry;

    // Shifting the whole PC keeps every PC bit in the tag path.
    assign idx_f = PCF[IDX_W+1:2];
    assign idx_e = PCE[IDX_W+1:2];
    assign tag_f = BPU_W'(PCF >> (IDX_W + 2));
    assign tag_e = BPU_W'(PCE >> (IDX_W + 2));

    assign hit_f = btb[idx_f].valid && (btb[idx_f].tag == tag_f);
    assign hit_e = btb[idx_e].valid && (btb[idx_e].tag == tag_e);

    // Lookup sees pre-edge table state; no bypass from same-cycle training.
    assign PredTakenF = PRED_EN && !reset && hit_f &&
                        (btb[idx_f].kind == KIND_JUMP || ctr[idx_f] >= WT);
    assign PredTargetF = (!reset && hit_f) ? btb[idx_f].target[XLEN-1:0] : '0;

    br_cond_eval u_cond (
        .fun3 (Fun3E),
        .n    (N),
        .z    (Z),
        .c    (C),
        .v    (V),
        .cond (cond_e)
    );

    assign PCJmpE = ValidE && ((JmpE == JMP_BRANCH && cond_e) || JmpE[1]);

    assign MispredictE = ValidE && !reset &&
                         ((PredTakenE != PCJmpE) ||
                          (PCJmpE && PredTargetE != TargetE));

    assign RedirectPCE = PCJmpE ? TargetE : PCE + XLEN'(4);

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = tag_e;
        wr_entry.target = BPU_W'(TargetE);
        wr_entry.kind   = (JmpE == JMP_JAL) ? KIND_JUMP : KIND_BRANCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i] <= '0;
                ctr[i] <= WNT;
            end
        end else if (ValidE && PRED_EN) begin
            unique case (JmpE)
                JMP_BRANCH: begin
                    ctr[idx_e] <= ctr_step(ctr[idx_e], PCJmpE);
                    if (PCJmpE) begin
                        btb[idx_e] <= wr_entry;
                    end
                end
                JMP_JAL: begin
                    btb[idx_e] <= wr_entry;
                end
                JMP_JALR: begin
                end
                JMP_NONE: begin
                    // A non-jump sitting in the BTB means the entry is stale.
                    if (hit_e) begin
                        btb[idx_e].valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            BrCount   <= '0;
            MissCount <= '0;
        end else begin
            if (ValidE && JmpE == JMP_BRANCH && !(&BrCount)) begin
                BrCount <= BrCount + CNT_W'(1);
            end
            if (MispredictE && !(&MissCount)) begin
                MissCount <= MissCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios plus random traffic.
// Three instances share inputs: default, CNT_W=2 and PRED_EN=0.
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] PCF, PCE, TargetE, PredTargetE;
    logic        ValidE, PredTakenE, N, Z, C, V;
    logic [1:0]  JmpE;
    logic [2:0]  Fun3E;

    logic        d_ptf, d_pcj, d_mis;
    logic [31:0] d_ptgt, d_red;
    logic [15:0] d_br, d_miss;
    logic        s_ptf, s_pcj, s_mis;
    logic [31:0] s_ptgt, s_red;
    logic [1:0]  s_br, s_miss;
    logic        o_ptf, o_pcj, o_mis;
    logic [31:0] o_ptgt, o_red;
    logic [15:0] o_br, o_miss;

    branch_pred_unit u_dut (
        .clk(clk), .reset(reset), .PCF(PCF),
        .PredTakenF(d_ptf), .PredTargetF(d_ptgt),
        .ValidE(ValidE), .JmpE(JmpE), .Fun3E(Fun3E),
        .N(N), .Z(Z), .C(C), .V(V),
        .PCE(PCE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PCJmpE(d_pcj), .MispredictE(d_mis), .RedirectPCE(d_red),
        .BrCount(d_br), .MissCount(d_miss)
    );

    branch_pred_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .PCF(PCF),
        .PredTakenF(s_ptf), .PredTargetF(s_ptgt),
        .ValidE(ValidE), .JmpE(JmpE), .Fun3E(Fun3E),
        .N(N), .Z(Z), .C(C), .V(V),
        .PCE(PCE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PCJmpE(s_pcj), .MispredictE(s_mis), .RedirectPCE(s_red),
        .BrCount(s_br), .MissCount(s_miss)
    );

    branch_pred_unit #(.PRED_EN(1'b0)) u_off (
        .clk(clk), .reset(reset), .PCF(PCF),
        .PredTakenF(o_ptf), .PredTargetF(o_ptgt),
        .ValidE(ValidE), .JmpE(JmpE), .Fun3E(Fun3E),
        .N(N), .Z(Z), .C(C), .V(V),
        .PCE(PCE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .PCJmpE(o_pcj), .MispredictE(o_mis), .RedirectPCE(o_red),
        .BrCount(o_br), .MissCount(o_miss)
    );

    // Reference model: 16 entries, tag = pc / 64, counter as integer 0..3.
    bit          mv   [16];
    bit [31:0]   mtag [16];
    bit [31:0]   mtgt [16];
    bit          mjmp [16];
    int          mctr [16];
    int          m_br, m_miss;
    int          nvec = 0;
    int          nerr = 0;

    function automatic int sat(input int a, input int m);
        return (a > m) ? m : a;
    endfunction

    function automatic int ix(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit hit(input logic [31:0] pc);
        return mv[ix(pc)] && (mtag[ix(pc)] == pc / 64);
    endfunction

    function automatic bit e_ptf(input logic [31:0] pc);
        return !reset && hit(pc) && (mjmp[ix(pc)] || mctr[ix(pc)] >= 2);
    endfunction

    function automatic logic [31:0] e_ptgt(input logic [31:0] pc);
        return (!reset && hit(pc)) ? mtgt[ix(pc)] : 32'h0;
    endfunction

    function automatic bit e_cond();
        case (Fun3E)
            3'd0:    return Z;
            3'd1:    return !Z;
            3'd4:    return N != V;
            3'd5:    return N == V;
            3'd6:    return !C;
            3'd7:    return C;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit e_taken();
        return ValidE && ((JmpE == 2'd1 && e_cond()) || JmpE >= 2'd2);
    endfunction

    function automatic bit e_mis();
        return ValidE && !reset &&
               ((PredTakenE != e_taken()) ||
                (e_taken() && PredTargetE != TargetE));
    endfunction

    function automatic logic [31:0] e_red();
        return e_taken() ? TargetE : PCE + 32'd4;
    endfunction

    function automatic logic [31:0] rpc();
        return 32'h1000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
    endfunction

    task automatic idle();
        ValidE = 0; JmpE = 0; Fun3E = 0;
        N = 0; Z = 0; C = 0; V = 0;
        PCE = 0; TargetE = 0; PredTakenE = 0; PredTargetE = 0;
    endtask

    task automatic exec(input logic [1:0] j, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic z,
                        input logic pt, input logic [31:0] ptg);
        idle();
        ValidE = 1; JmpE = j; Fun3E = 3'd0; Z = z;
        PCE = pc; TargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
        #1;
    endtask

    // Advance model across the edge using pre-edge inputs, then the DUT.
    task automatic tick();
        int i;
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                mv[k] = 0;
                mctr[k] = 1;
            end
            m_br = 0;
            m_miss = 0;
        end else begin
            if (e_mis()) m_miss++;
            if (ValidE) begin
                i = ix(PCE);
                if (JmpE == 2'd1) begin
                    m_br++;
                    if (e_taken()) begin
                        mctr[i] = sat(mctr[i] + 1, 3);
                        mv[i] = 1; mtag[i] = PCE / 64; mtgt[i] = TargetE; mjmp[i] = 0;
                    end else begin
                        mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
                    end
                end else if (JmpE == 2'd2) begin
                    mv[i] = 1; mtag[i] = PCE / 64; mtgt[i] = TargetE; mjmp[i] = 1;
                end else if (JmpE == 2'd0 && hit(PCE)) begin
                    mv[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; PCF = 32'h100; idle();
        tick(); tick();
        reset = 0; #1;
        nvec++; if (d_ptf !== 1'b0) begin nerr++; $display("FAIL rst_ptf: got %0b want 0", d_ptf); end
        nvec++; if (d_ptgt !== 32'h0) begin nerr++; $display("FAIL rst_ptgt: got %h want 0", d_ptgt); end
        nvec++; if (d_br !== 16'd0) begin nerr++; $display("FAIL rst_br: got %0d want 0", d_br); end
        nvec++; if (d_miss !== 16'd0) begin nerr++; $display("FAIL rst_miss: got %0d want 0", d_miss); end
    endtask

    task automatic test_branch();
        exec(2'd1, 32'h100, 32'h140, 1, 0, 0);
        nvec++; if ({d_pcj, d_mis} !== 2'b11) begin nerr++; $display("FAIL br_first: got %b want 11", {d_pcj, d_mis}); end
        nvec++; if (d_red !== 32'h140) begin nerr++; $display("FAIL br_red: got %h want 140", d_red); end
        tick(); idle(); PCF = 32'h100; #1;
        nvec++; if (d_miss !== 16'd1) begin nerr++; $display("FAIL br_miss1: got %0d want 1", d_miss); end
        nvec++; if ({d_ptf, d_ptgt} !== {1'b1, 32'h140}) begin nerr++; $display("FAIL br_pred: got %0b/%h want 1/140", d_ptf, d_ptgt); end
        for (int k = 0; k < 3; k++) begin
            exec(2'd1, 32'h100, 32'h140, 1, 1, 32'h140);
            nvec++; if (d_mis !== 1'b0) begin nerr++; $display("FAIL br_hit%0d: got %0b want 0", k, d_mis); end
            tick();
        end
        exec(2'd1, 32'h100, 32'h140, 0, 1, 32'h140);
        nvec++; if ({d_pcj, d_mis, d_red} !== {2'b01, 32'h104}) begin nerr++; $display("FAIL br_nt: got %0b/%0b/%h want 0/1/104", d_pcj, d_mis, d_red); end
        tick(); idle(); #1;
        nvec++; if ({d_br, d_miss, d_ptf} !== {16'd5, 16'd2, 1'b1}) begin nerr++; $display("FAIL br_cnt: got %0d/%0d/%0b want 5/2/1", d_br, d_miss, d_ptf); end
        exec(2'd1, 32'h100, 32'h140, 0, 1, 32'h140);
        tick(); idle(); #1;
        nvec++; if ({d_ptf, d_ptgt} !== {1'b0, 32'h140}) begin nerr++; $display("FAIL br_weak: got %0b/%h want 0/140", d_ptf, d_ptgt); end
        nvec++; if ({d_br, d_miss} !== {16'd6, 16'd3}) begin nerr++; $display("FAIL br_cnt2: got %0d/%0d want 6/3", d_br, d_miss); end
    endtask

    task automatic test_jump();
        exec(2'd2, 32'h200, 32'h080, 0, 0, 0);
        nvec++; if ({d_pcj, d_mis, d_red} !== {2'b11, 32'h080}) begin nerr++; $display("FAIL jal: got %0b/%0b/%h want 1/1/80", d_pcj, d_mis, d_red); end
        tick();
        exec(2'd1, 32'h200, 32'h240, 0, 0, 0); tick();
        exec(2'd1, 32'h200, 32'h240, 0, 0, 0); tick();
        idle(); PCF = 32'h200; #1;
        nvec++; if ({d_ptf, d_ptgt} !== {1'b1, 32'h080}) begin nerr++; $display("FAIL jal_pred: got %0b/%h want 1/80", d_ptf, d_ptgt); end
        exec(2'd3, 32'h304, 32'h500, 0, 0, 0);
        nvec++; if ({d_pcj, d_mis, d_red} !== {2'b11, 32'h500}) begin nerr++; $display("FAIL jalr: got %0b/%0b/%h want 1/1/500", d_pcj, d_mis, d_red); end
        tick();
        exec(2'd3, 32'h200, 32'h700, 0, 1, 32'h080);
        nvec++; if (d_mis !== 1'b1) begin nerr++; $display("FAIL jalr_tgt: got %0b want 1", d_mis); end
        tick(); idle(); PCF = 32'h304; #1;
        nvec++; if (d_ptf !== 1'b0) begin nerr++; $display("FAIL jalr_noalloc: got %0b want 0", d_ptf); end
        PCF = 32'h200; #1;
        nvec++; if (d_ptgt !== 32'h080) begin nerr++; $display("FAIL jalr_keep: got %h want 80", d_ptgt); end
        exec(2'd3, 32'h200, 32'h080, 0, 1, 32'h080);
        nvec++; if (d_mis !== 1'b0) begin nerr++; $display("FAIL jalr_match: got %0b want 0", d_mis); end
        tick();
    endtask

    task automatic test_alias();
        exec(2'd1, 32'h100, 32'h140, 1, 0, 0); tick();
        exec(2'd1, 32'h140, 32'h180, 1, 0, 0); tick();
        idle(); PCF = 32'h100; #1;
        nvec++; if ({d_ptf, d_ptgt} !== 33'h0) begin nerr++; $display("FAIL alias_old: got %0b/%h want 0/0", d_ptf, d_ptgt); end
        PCF = 32'h140; #1;
        nvec++; if ({d_ptf, d_ptgt} !== {1'b1, 32'h180}) begin nerr++; $display("FAIL alias_new: got %0b/%h want 1/180", d_ptf, d_ptgt); end
        exec(2'd2, 32'h140, 32'h1C0, 0, 1, 32'h180);
        nvec++; if (d_ptgt !== 32'h180) begin nerr++; $display("FAIL same_cycle: got %h want 180", d_ptgt); end
        tick(); idle(); #1;
        nvec++; if (d_ptgt !== 32'h1C0) begin nerr++; $display("FAIL same_after: got %h want 1c0", d_ptgt); end
        exec(2'd0, 32'h140, 32'h0, 0, 0, 0);
        nvec++; if ({d_pcj, d_mis, d_red} !== {2'b00, 32'h144}) begin nerr++; $display("FAIL stale_exec: got %0b/%0b/%h want 0/0/144", d_pcj, d_mis, d_red); end
        tick(); idle(); #1;
        nvec++; if ({d_ptf, d_ptgt} !== 33'h0) begin nerr++; $display("FAIL stale_clr: got %0b/%h want 0/0", d_ptf, d_ptgt); end
    endtask

    task automatic test_reset_mid();
        exec(2'd2, 32'h400, 32'h600, 0, 1, 32'h600); tick();
        idle(); PCF = 32'h400; #1;
        nvec++; if (d_ptf !== 1'b1) begin nerr++; $display("FAIL mid_pre: got %0b want 1", d_ptf); end
        exec(2'd1, 32'h400, 32'h800, 1, 0, 0);
        reset = 1; #1;
        nvec++; if ({d_mis, d_ptf, d_ptgt} !== 34'h0) begin nerr++; $display("FAIL mid_rst: got %0b/%0b/%h want 0/0/0", d_mis, d_ptf, d_ptgt); end
        tick();
        reset = 0; idle(); #1;
        nvec++; if ({d_ptf, d_ptgt} !== 33'h0) begin nerr++; $display("FAIL mid_clr: got %0b/%h want 0/0", d_ptf, d_ptgt); end
        nvec++; if ({d_br, d_miss, s_miss} !== 34'h0) begin nerr++; $display("FAIL mid_cnt: got %0d/%0d/%0d want 0/0/0", d_br, d_miss, s_miss); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 4; k++) begin
            exec(2'd3, 32'h800, 32'h900, 0, 0, 0);
            tick();
        end
        idle(); #1;
        nvec++; if (s_miss !== 2'd3) begin nerr++; $display("FAIL sat_miss2: got %0d want 3", s_miss); end
        nvec++; if (d_miss !== 16'd4) begin nerr++; $display("FAIL sat_miss16: got %0d want 4", d_miss); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            PCF = rpc(); PCE = rpc(); TargetE = rpc();
            ValidE = ($urandom_range(0, 9) != 0);
            JmpE = 2'($urandom_range(0, 3));
            Fun3E = 3'($urandom_range(0, 7));
            {N, Z, C, V} = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                PredTakenE = e_ptf(PCE); PredTargetE = e_ptgt(PCE);
            end else begin
                PredTakenE = 1'($urandom);
                PredTargetE = ($urandom_range(0, 1) == 1) ? TargetE : rpc();
            end
            #1;
            nvec++; if ({d_pcj, d_mis, d_red} !== {e_taken(), e_mis(), e_red()}) begin nerr++;
                $display("FAIL rnd_exec[%0d]: got %0b/%0b/%h want %0b/%0b/%h", n, d_pcj, d_mis, d_red, e_taken(), e_mis(), e_red()); end
            nvec++; if ({d_ptf, d_ptgt} !== {e_ptf(PCF), e_ptgt(PCF)}) begin nerr++;
                $display("FAIL rnd_pred[%0d]: got %0b/%h want %0b/%h", n, d_ptf, d_ptgt, e_ptf(PCF), e_ptgt(PCF)); end
            nvec++; if ({d_br, d_miss} !== {16'(sat(m_br, 65535)), 16'(sat(m_miss, 65535))}) begin nerr++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, d_br, d_miss, m_br, m_miss); end
            nvec++; if ({s_ptf, s_ptgt, s_pcj, s_mis, s_red} !== {e_ptf(PCF), e_ptgt(PCF), e_taken(), e_mis(), e_red()}) begin nerr++;
                $display("FAIL rnd_sat_out[%0d]: got %0b/%h/%0b/%0b/%h", n, s_ptf, s_ptgt, s_pcj, s_mis, s_red); end
            nvec++; if ({s_br, s_miss} !== {2'(sat(m_br, 3)), 2'(sat(m_miss, 3))}) begin nerr++;
                $display("FAIL rnd_sat_cnt[%0d]: got %0d/%0d want %0d/%0d", n, s_br, s_miss, sat(m_br, 3), sat(m_miss, 3)); end
            nvec++; if ({o_ptf, o_ptgt} !== 33'h0) begin nerr++;
                $display("FAIL rnd_off_pred[%0d]: got %0b/%h want 0/0", n, o_ptf, o_ptgt); end
            nvec++; if ({o_pcj, o_mis, o_red, o_br, o_miss} !== {e_taken(), e_mis(), e_red(), 16'(sat(m_br, 65535)), 16'(sat(m_miss, 65535))}) begin nerr++;
                $display("FAIL rnd_off_exec[%0d]: got %0b/%0b/%h/%0d/%0d", n, o_pcj, o_mis, o_red, o_br, o_miss); end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_alias();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
